// File: rtl/pcim_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pcim_rd_arbiter
// Description : Shares one PCIM AXI4 read master (AR/R) between NUM_REQ
//               requesters. Round-robin AR arbitration gated by per-requester
//               outstanding-burst credits; requester index travels in arid and
//               R beats are steered back by rid.
//               Optional statistics counters: define PCIM_RD_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pcim_rd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 8,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int ID_W    = 16
) (
    input  logic                      clk_main_a0,
    input  logic                      rst_main,
    input  logic [NUM_REQ-1:0]        req_arvalid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
    input  logic [NUM_REQ*8-1:0]      req_arlen,
    output logic [NUM_REQ-1:0]        req_arready,
    output logic [NUM_REQ-1:0]        req_rvalid,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [1:0]                req_rresp,
    output logic                      req_rlast,
    input  logic [NUM_REQ-1:0]        req_rready,
    output logic                      pcim_arvalid,
    output logic [ADDR_W-1:0]         pcim_araddr,
    output logic [7:0]                pcim_arlen,
    output logic [2:0]                pcim_arsize,
    output logic [ID_W-1:0]           pcim_arid,
    output logic [18:0]               pcim_aruser,
    input  logic                      pcim_arready,
    input  logic                      pcim_rvalid,
    input  logic [DATA_W-1:0]         pcim_rdata,
    input  logic [1:0]                pcim_rresp,
    input  logic                      pcim_rlast,
    input  logic [ID_W-1:0]           pcim_rid,
    output logic                      pcim_rready,
    output logic                      err_bad_rid,
    output logic                      err_underflow,
    output logic                      outstanding_any
`ifdef PCIM_RD_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]     stat_grants,
    output logic [31:0]               stat_ar_stall
`endif
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // AR slot and arbitration state
    logic               r_arvalid;
    logic [ADDR_W-1:0]  r_araddr;
    logic [7:0]         r_arlen;
    logic [ID_W-1:0]    r_arid;
    logic [c_IDX_W-1:0] r_ptr;
    logic [3:0]         r_cnt [NUM_REQ];
    logic               r_err_bad;
    logic               r_err_uf;

    logic               w_slot_free;
    logic [NUM_REQ-1:0] w_elig;
    logic               w_grant_vld;
    logic [c_IDX_W-1:0] w_grant_idx;
    logic [c_IDX_W-1:0] w_scan_idx;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [7:0]         w_sel_len;
    logic               w_rid_ok;
    logic [c_IDX_W-1:0] w_rid_idx;
    logic               w_rready;
    logic               w_r_done;
    logic [NUM_REQ-1:0] w_inc;
    logic [NUM_REQ-1:0] w_dec;
    logic [NUM_REQ-1:0] w_uf;
    logic               w_any;

    // The slot can take a new request when empty or draining this cycle
    assign w_slot_free = !r_arvalid || pcim_arready;

    // A requester at its credit limit is invisible to the arbiter
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
        assign w_elig[gi] = req_arvalid[gi] && (r_cnt[gi] < 4'(MAX_OUT));
    end

    // Round-robin search: first eligible index at or after the pointer
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan_idx = c_IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_grant_vld && w_elig[w_scan_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
    end

    // Requests are never accepted while reset is asserted
    assign w_accept = w_slot_free && w_grant_vld && !rst_main;

    // One-hot accept toward the winner, plus its request fields
    always_comb begin
        req_arready = '0;
        w_sel_addr  = '0;
        w_sel_len   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == c_IDX_W'(i)) begin
                w_sel_addr = req_araddr[i*ADDR_W +: ADDR_W];
                w_sel_len  = req_arlen[i*8 +: 8];
            end
        end
        if (w_accept) begin
            req_arready[w_grant_idx] = 1'b1;
        end
    end

    // AR slot register and round-robin pointer
    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arid    <= '0;
            r_ptr     <= '0;
        end else if (w_accept) begin
            r_arvalid <= 1'b1;
            r_araddr  <= w_sel_addr;
            r_arlen   <= w_sel_len;
            r_arid    <= ID_W'(w_grant_idx);
            r_ptr     <= (w_grant_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
        end else if (pcim_arready) begin
            r_arvalid <= 1'b0;
        end
    end

    assign pcim_arvalid = r_arvalid;
    assign pcim_araddr  = r_araddr;
    assign pcim_arlen   = r_arlen;
    assign pcim_arid    = r_arid;
    assign pcim_arsize  = 3'b110;
    assign pcim_aruser  = '0;

    // R steering: unknown rids are swallowed so the shell never stalls on them
    assign w_rid_ok    = (pcim_rid < ID_W'(NUM_REQ));
    assign w_rid_idx   = pcim_rid[c_IDX_W-1:0];
    assign w_rready    = w_rid_ok ? req_rready[w_rid_idx] : 1'b1;
    assign pcim_rready = w_rready;
    assign w_r_done    = pcim_rvalid && w_rready && pcim_rlast && w_rid_ok;
    assign req_rdata   = pcim_rdata;
    assign req_rresp   = pcim_rresp;
    assign req_rlast   = pcim_rlast;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_route
        assign req_rvalid[gi] = pcim_rvalid && w_rid_ok && (w_rid_idx == c_IDX_W'(gi));
        assign w_inc[gi]      = w_accept && (w_grant_idx == c_IDX_W'(gi));
        assign w_dec[gi]      = w_r_done && (w_rid_idx == c_IDX_W'(gi));
        assign w_uf[gi]       = w_dec[gi] && !w_inc[gi] && (r_cnt[gi] == 4'd0);
    end

    // Credit counters: accept adds one, final beat returns one, both cancel
    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != 4'd0)) begin
                    r_cnt[i] <= r_cnt[i] - 4'd1;
                end
            end
        end
    end

    // Sticky protocol error flags
    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            r_err_bad <= 1'b0;
            r_err_uf  <= 1'b0;
        end else begin
            r_err_bad <= r_err_bad | (pcim_rvalid && !w_rid_ok);
            r_err_uf  <= r_err_uf | (|w_uf);
        end
    end

    assign err_bad_rid   = r_err_bad;
    assign err_underflow = r_err_uf;

    // Anything in flight: a pending slot or any non-zero credit counter
    always_comb begin
        w_any = r_arvalid;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_cnt[i] != 4'd0) begin
                w_any = 1'b1;
            end
        end
    end

    assign outstanding_any = w_any;

`ifdef PCIM_RD_ARB_STATS_EN
    logic [NUM_REQ*32-1:0] r_stat_grants;
    logic [31:0]           r_stat_stall;

    // Free-running wrap-around grant and AR stall counters
    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            r_stat_grants <= '0;
            r_stat_stall  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_inc[i]) begin
                    r_stat_grants[i*32 +: 32] <= r_stat_grants[i*32 +: 32] + 32'd1;
                end
            end
            if (r_arvalid && !pcim_arready) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_grants   = r_stat_grants;
    assign stat_ar_stall = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcim_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcim_rd_arbiter
// Description : Self-checking bench for pcim_rd_arbiter: directed scenarios
//               plus randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcim_rd_arbiter;

    localparam int NR = 4;
    localparam int MO = 8;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int IW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_arvalid;
    logic [NR*AW-1:0] req_araddr;
    logic [NR*8-1:0]  req_arlen;
    logic [NR-1:0]    req_arready;
    logic [NR-1:0]    req_rvalid;
    logic [DW-1:0]    req_rdata;
    logic [1:0]       req_rresp;
    logic             req_rlast;
    logic [NR-1:0]    req_rready;
    logic             pcim_arvalid;
    logic [AW-1:0]    pcim_araddr;
    logic [7:0]       pcim_arlen;
    logic [2:0]       pcim_arsize;
    logic [IW-1:0]    pcim_arid;
    logic [18:0]      pcim_aruser;
    logic             pcim_arready;
    logic             pcim_rvalid;
    logic [DW-1:0]    pcim_rdata;
    logic [1:0]       pcim_rresp;
    logic             pcim_rlast;
    logic [IW-1:0]    pcim_rid;
    logic             pcim_rready;
    logic             err_bad_rid;
    logic             err_underflow;
    logic             outstanding_any;
`ifdef PCIM_RD_ARB_STATS_EN
    logic [NR*32-1:0] stat_grants;
    logic [31:0]      stat_ar_stall;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pcim_rd_arbiter #(
        .NUM_REQ(NR), .MAX_OUT(MO), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)
    ) dut (
        .clk_main_a0    (clk),
        .rst_main       (rst),
        .req_arvalid    (req_arvalid),
        .req_araddr     (req_araddr),
        .req_arlen      (req_arlen),
        .req_arready    (req_arready),
        .req_rvalid     (req_rvalid),
        .req_rdata      (req_rdata),
        .req_rresp      (req_rresp),
        .req_rlast      (req_rlast),
        .req_rready     (req_rready),
        .pcim_arvalid   (pcim_arvalid),
        .pcim_araddr    (pcim_araddr),
        .pcim_arlen     (pcim_arlen),
        .pcim_arsize    (pcim_arsize),
        .pcim_arid      (pcim_arid),
        .pcim_aruser    (pcim_aruser),
        .pcim_arready   (pcim_arready),
        .pcim_rvalid    (pcim_rvalid),
        .pcim_rdata     (pcim_rdata),
        .pcim_rresp     (pcim_rresp),
        .pcim_rlast     (pcim_rlast),
        .pcim_rid       (pcim_rid),
        .pcim_rready    (pcim_rready),
        .err_bad_rid    (err_bad_rid),
        .err_underflow  (err_underflow),
        .outstanding_any(outstanding_any)
`ifdef PCIM_RD_ARB_STATS_EN
        ,
        .stat_grants    (stat_grants),
        .stat_ar_stall  (stat_ar_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change on the falling edge; the DUT registers on the rising edge
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_arvalid  = '0;
        req_araddr   = '0;
        req_arlen    = '0;
        req_rready   = '0;
        pcim_arready = 1'b0;
        pcim_rvalid  = 1'b0;
        pcim_rdata   = '0;
        pcim_rresp   = '0;
        pcim_rlast   = 1'b0;
        pcim_rid     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        req_arvalid = 4'hf;
        #1;
        n_checks++; if (req_arready !== 4'b0) $display("FAIL rst_arready got=%b exp=0000", req_arready); else n_pass++;
        tick();
        rst = 1'b0;
        req_arvalid = '0;
        #1;
        n_checks++; if (pcim_arvalid !== 1'b0) $display("FAIL rst_arvalid got=%b exp=0", pcim_arvalid); else n_pass++;
        n_checks++; if ({pcim_araddr, pcim_arlen, pcim_arid} !== '0) $display("FAIL rst_slot got=%h exp=0", {pcim_araddr, pcim_arlen, pcim_arid}); else n_pass++;
        n_checks++; if (pcim_arsize !== 3'b110) $display("FAIL rst_arsize got=%b exp=110", pcim_arsize); else n_pass++;
        n_checks++; if (pcim_aruser !== 19'd0) $display("FAIL rst_aruser got=%h exp=0", pcim_aruser); else n_pass++;
        n_checks++; if ({err_bad_rid, err_underflow, outstanding_any} !== 3'b000) $display("FAIL rst_flags got=%b exp=000", {err_bad_rid, err_underflow, outstanding_any}); else n_pass++;
`ifdef PCIM_RD_ARB_STATS_EN
        n_checks++; if ({stat_grants, stat_ar_stall} !== '0) $display("FAIL rst_stats got=%h exp=0", {stat_grants, stat_ar_stall}); else n_pass++;
`endif
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        do_reset();
        req_arvalid = 4'b0100;
        req_araddr[2*AW +: AW] = 64'h1000;
        req_arlen[2*8 +: 8] = 8'd3;
        #1;
        n_checks++; if (req_arready !== 4'b0100) $display("FAIL single_arready got=%b exp=0100", req_arready); else n_pass++;
        tick();
        req_arvalid = '0;
        #1;
        n_checks++; if (pcim_arvalid !== 1'b1) $display("FAIL single_arvalid got=%b exp=1", pcim_arvalid); else n_pass++;
        n_checks++; if ({pcim_arid, pcim_arlen, pcim_araddr} !== {16'd2, 8'd3, 64'h1000}) $display("FAIL single_slot got=%h/%h/%h exp=2/3/1000", pcim_arid, pcim_arlen, pcim_araddr); else n_pass++;
        n_checks++; if (dut.r_cnt[2] !== 4'd1) $display("FAIL single_cnt_up got=%0d exp=1", dut.r_cnt[2]); else n_pass++;
        pcim_arready = 1'b1;
        tick();
        pcim_arready = 1'b0;
        req_rready = 4'hf;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom();
            pcim_rvalid = 1'b1;
            pcim_rid    = 16'd2;
            pcim_rlast  = (b == 3);
            pcim_rdata  = d;
            #1;
            n_checks++; if (req_rvalid !== 4'b0100) $display("FAIL single_rvalid beat%0d got=%b exp=0100", b, req_rvalid); else n_pass++;
            n_checks++; if ({req_rdata, req_rlast, pcim_rready} !== {d, (b == 3), 1'b1}) $display("FAIL single_rdata beat%0d got_last=%b exp_last=%b", b, req_rlast, (b == 3)); else n_pass++;
            tick();
        end
        pcim_rvalid = 1'b0;
        pcim_rlast  = 1'b0;
        #1;
        n_checks++; if (dut.r_cnt[2] !== 4'd0) $display("FAIL single_cnt_down got=%0d exp=0", dut.r_cnt[2]); else n_pass++;
        n_checks++; if ({outstanding_any, err_underflow} !== 2'b00) $display("FAIL single_idle got=%b exp=00", {outstanding_any, err_underflow}); else n_pass++;
    endtask

    task automatic test_fairness();
        do_reset();
        req_arvalid = 4'hf;
        for (int i = 0; i < NR; i++) begin
            req_araddr[i*AW +: AW] = 64'(i * 256);
            req_arlen[i*8 +: 8] = 8'(i);
        end
        pcim_arready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_checks++; if (req_arready !== 4'(1 << (c % NR))) $display("FAIL fair_grant c%0d got=%b exp=%b", c, req_arready, 4'(1 << (c % NR))); else n_pass++;
            if (c > 0) begin
                n_checks++; if ({pcim_arvalid, pcim_arid, pcim_araddr} !== {1'b1, 16'((c-1) % NR), 64'(((c-1) % NR) * 256)}) $display("FAIL fair_arid c%0d got=%0d exp=%0d", c, pcim_arid, (c-1) % NR); else n_pass++;
            end
            tick();
        end
        req_arvalid = '0;
        #1;
        n_checks++; if (pcim_arid !== 16'd3) $display("FAIL fair_last_arid got=%0d exp=3", pcim_arid); else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_arvalid = 4'b0001;
        req_araddr[0 +: AW] = 64'hA000;
        #1;
        n_checks++; if (req_arready !== 4'b0001) $display("FAIL bp_first got=%b exp=0001", req_arready); else n_pass++;
        tick();
        req_araddr[0 +: AW] = 64'hB000;
        for (int s = 0; s < 5; s++) begin
            #1;
            n_checks++; if ({req_arready, pcim_arvalid, pcim_araddr} !== {4'b0000, 1'b1, 64'hA000}) $display("FAIL bp_stall s%0d got=%b/%b/%h exp=0000/1/a000", s, req_arready, pcim_arvalid, pcim_araddr); else n_pass++;
            tick();
        end
        pcim_arready = 1'b1;
        for (int g = 0; g < 7; g++) begin
            #1;
            n_checks++; if (req_arready !== 4'b0001) $display("FAIL bp_credit g%0d got=%b exp=0001", g, req_arready); else n_pass++;
            tick();
        end
        req_arvalid = 4'b0011;
        #1;
        n_checks++; if (req_arready !== 4'b0010) $display("FAIL bp_limit got=%b exp=0010", req_arready); else n_pass++;
        n_checks++; if (dut.r_cnt[0] !== 4'd8) $display("FAIL bp_cnt0 got=%0d exp=8", dut.r_cnt[0]); else n_pass++;
        tick();
        req_arvalid = '0;
        #1;
        n_checks++; if (pcim_arid !== 16'd1) $display("FAIL bp_arid got=%0d exp=1", pcim_arid); else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        pcim_arready = 1'b1;
        req_arvalid = 4'b0010;
        tick();
        tick();
        tick();
        pcim_rvalid = 1'b1;
        pcim_rid    = 16'd1;
        pcim_rlast  = 1'b1;
        req_rready  = 4'hf;
        #1;
        n_checks++; if (dut.r_cnt[1] !== 4'd3) $display("FAIL sim_cnt_pre got=%0d exp=3", dut.r_cnt[1]); else n_pass++;
        n_checks++; if ({req_arready, req_rvalid} !== {4'b0010, 4'b0010}) $display("FAIL sim_both got=%b/%b exp=0010/0010", req_arready, req_rvalid); else n_pass++;
        tick();
        req_arvalid = '0;
        pcim_rvalid = 1'b0;
        #1;
        n_checks++; if (dut.r_cnt[1] !== 4'd3) $display("FAIL sim_cnt_post got=%0d exp=3", dut.r_cnt[1]); else n_pass++;
        pcim_rvalid = 1'b1;
        pcim_rid    = 16'd7;
        req_rready  = '0;
        #1;
        n_checks++; if ({pcim_rready, req_rvalid} !== {1'b1, 4'b0000}) $display("FAIL badrid_route got=%b/%b exp=1/0000", pcim_rready, req_rvalid); else n_pass++;
        tick();
        pcim_rvalid = 1'b0;
        pcim_rlast  = 1'b0;
        #1;
        n_checks++; if ({err_bad_rid, err_underflow} !== 2'b10) $display("FAIL badrid_flags got=%b exp=10", {err_bad_rid, err_underflow}); else n_pass++;
        n_checks++; if (dut.r_cnt[1] !== 4'd3) $display("FAIL badrid_cnt got=%0d exp=3", dut.r_cnt[1]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        pcim_arready = 1'b1;
        req_arvalid = 4'b0001;
        tick();
        tick();
        pcim_arready = 1'b0;
        req_arvalid = '0;
        #1;
        n_checks++; if ({pcim_arvalid, dut.r_cnt[0]} !== {1'b1, 4'd2}) $display("FAIL mid_pre got=%b/%0d exp=1/2", pcim_arvalid, dut.r_cnt[0]); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if ({pcim_arvalid, outstanding_any, dut.r_cnt[0]} !== {1'b0, 1'b0, 4'd0}) $display("FAIL mid_post got=%b/%b/%0d exp=0/0/0", pcim_arvalid, outstanding_any, dut.r_cnt[0]); else n_pass++;
        pcim_rvalid = 1'b1;
        pcim_rid    = 16'd0;
        pcim_rlast  = 1'b1;
        req_rready  = 4'b0001;
        #1;
        n_checks++; if (req_rvalid !== 4'b0001) $display("FAIL mid_late_route got=%b exp=0001", req_rvalid); else n_pass++;
        tick();
        pcim_rvalid = 1'b0;
        pcim_rlast  = 1'b0;
        #1;
        n_checks++; if ({err_underflow, dut.r_cnt[0]} !== {1'b1, 4'd0}) $display("FAIL mid_underflow got=%b/%0d exp=1/0", err_underflow, dut.r_cnt[0]); else n_pass++;
    endtask

    // Model: slot + pointer + credit counts; bursts issued to the shell are
    // queued in order and returned beat by beat with random R stimulus.
    task automatic test_random();
        bit            m_av;
        logic [AW-1:0] m_addr;
        logic [7:0]    m_len;
        int            m_id;
        int            m_ptr;
        int            m_cnt [NR];
        bit            m_bad;
        int            q_rid [$];
        int            q_rem [$];
        int            win;
        int            rid;
        bit            beat;
        bit            e_rr;
        bit            e_any;
        logic [NR-1:0] e_ardy;
        logic [NR-1:0] e_rv;
        logic [DW-1:0] d;
        do_reset();
        m_av = 0; m_addr = '0; m_len = '0; m_id = 0; m_ptr = 0; m_bad = 0;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                req_arvalid[i] = ($urandom_range(0, 9) < 6);
                req_araddr[i*AW +: AW] = {$urandom(), $urandom()};
                req_arlen[i*8 +: 8] = 8'($urandom_range(0, 3));
            end
            pcim_arready = ($urandom_range(0, 9) < 7);
            req_rready   = 4'($urandom());
            for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom();
            pcim_rdata  = d;
            pcim_rresp  = 2'($urandom());
            pcim_rvalid = 1'b0;
            pcim_rlast  = 1'b0;
            pcim_rid    = '0;
            beat = 0;
            if (q_rid.size() > 0 && $urandom_range(0, 9) < 7) begin
                pcim_rvalid = 1'b1;
                pcim_rid    = 16'(q_rid[0]);
                pcim_rlast  = (q_rem[0] == 1);
                beat = 1;
            end else if ($urandom_range(0, 49) == 0) begin
                pcim_rvalid = 1'b1;
                pcim_rid    = 16'($urandom_range(NR, 65535));
                pcim_rlast  = 1'($urandom_range(0, 1));
            end
            rid = int'(pcim_rid);
            win = -1;
            if (!m_av || pcim_arready) begin
                for (int k = 0; k < NR; k++) begin
                    int j = (m_ptr + k) % NR;
                    if (win < 0 && req_arvalid[j] && m_cnt[j] < MO) win = j;
                end
            end
            e_ardy = (win >= 0) ? 4'(1 << win) : 4'b0;
            e_rv   = (pcim_rvalid && rid < NR) ? 4'(1 << rid) : 4'b0;
            e_rr   = (rid < NR) ? req_rready[rid] : 1'b1;
            e_any  = m_av;
            for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) e_any = 1;
            #1;
            n_checks++; if (req_arready !== e_ardy) $display("FAIL rnd_arready c%0d got=%b exp=%b", cyc, req_arready, e_ardy); else n_pass++;
            n_checks++; if (pcim_arvalid !== m_av) $display("FAIL rnd_arvalid c%0d got=%b exp=%b", cyc, pcim_arvalid, m_av); else n_pass++;
            if (m_av) begin
                n_checks++; if ({pcim_arid, pcim_arlen, pcim_araddr} !== {16'(m_id), m_len, m_addr}) $display("FAIL rnd_slot c%0d got=%0d/%0d/%h exp=%0d/%0d/%h", cyc, pcim_arid, pcim_arlen, pcim_araddr, m_id, m_len, m_addr); else n_pass++;
            end
            n_checks++; if ({req_rvalid, pcim_rready} !== {e_rv, e_rr}) $display("FAIL rnd_rroute c%0d got=%b/%b exp=%b/%b", cyc, req_rvalid, pcim_rready, e_rv, e_rr); else n_pass++;
            n_checks++; if ({req_rdata, req_rresp, req_rlast} !== {d, pcim_rresp, pcim_rlast}) $display("FAIL rnd_rdata c%0d", cyc); else n_pass++;
            n_checks++; if (outstanding_any !== e_any) $display("FAIL rnd_outstanding c%0d got=%b exp=%b", cyc, outstanding_any, e_any); else n_pass++;
            n_checks++; if ({err_bad_rid, err_underflow} !== {m_bad, 1'b0}) $display("FAIL rnd_errs c%0d got=%b exp=%b0", cyc, {err_bad_rid, err_underflow}, m_bad); else n_pass++;
            for (int i = 0; i < NR; i++) begin
                n_checks++; if (dut.r_cnt[i] !== 4'(m_cnt[i])) $display("FAIL rnd_cnt%0d c%0d got=%0d exp=%0d", i, cyc, dut.r_cnt[i], m_cnt[i]); else n_pass++;
            end
            if (beat && req_rready[q_rid[0]]) begin
                q_rem[0] = q_rem[0] - 1;
                if (q_rem[0] == 0) begin
                    m_cnt[q_rid[0]] = m_cnt[q_rid[0]] - 1;
                    void'(q_rid.pop_front());
                    void'(q_rem.pop_front());
                end
            end
            if (m_av && pcim_arready) begin
                q_rid.push_back(m_id);
                q_rem.push_back(int'(m_len) + 1);
            end
            if (pcim_rvalid && rid >= NR) m_bad = 1;
            if (win >= 0) begin
                m_cnt[win] = m_cnt[win] + 1;
                m_av   = 1;
                m_addr = req_araddr[win*AW +: AW];
                m_len  = req_arlen[win*8 +: 8];
                m_id   = win;
                m_ptr  = (win + 1) % NR;
            end else if (pcim_arready) begin
                m_av = 0;
            end
            tick();
        end
        idle_inputs();
    endtask

`ifdef PCIM_RD_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        req_arvalid = 4'b1000;
        tick();
        req_arvalid = '0;
        tick();
        tick();
        tick();
        tick();
        pcim_arready = 1'b1;
        req_arvalid  = 4'b1000;
        req_rready   = 4'hf;
        pcim_rvalid  = 1'b1;
        pcim_rid     = 16'd3;
        pcim_rlast   = 1'b1;
        for (int g = 0; g < 9; g++) tick();
        req_arvalid = '0;
        pcim_rvalid = 1'b0;
        pcim_rlast  = 1'b0;
        tick();
        #1;
        n_checks++; if (stat_grants[3*32 +: 32] !== 32'd10) $display("FAIL stats_grants3 got=%0d exp=10", stat_grants[3*32 +: 32]); else n_pass++;
        n_checks++; if (stat_grants[0 +: 32] !== 32'd0) $display("FAIL stats_grants0 got=%0d exp=0", stat_grants[0 +: 32]); else n_pass++;
        n_checks++; if (stat_ar_stall !== 32'd4) $display("FAIL stats_stall got=%0d exp=4", stat_ar_stall); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_random();
`ifdef PCIM_RD_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
